// File: rtl/pwm_seq_pkg.sv
// Shared types and helpers for the PWM decode sequencer.
// Pure definitions: no latency, no flow control.
package pwm_seq_pkg;

   localparam int SAMPLE_W = 16;
   localparam int SYM_W    = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      ACTIVE = 3'd2,
      SETTLE = 3'd3,
      EMIT   = 3'd4
   } seq_state_t;

   // One extra bit so that the most negative sample maps to +32768 without wrapping.
   function automatic logic [SAMPLE_W:0] mag17(input logic signed [SAMPLE_W-1:0] x);
      logic signed [SAMPLE_W:0] ext;
      ext = {x[SAMPLE_W-1], x};
      return x[SAMPLE_W-1] ? $unsigned(-ext) : $unsigned(ext);
   endfunction

   function automatic logic [SAMPLE_W:0] clamp_ref(input logic signed [SAMPLE_W-1:0] x);
      return x[SAMPLE_W-1] ? '0 : {1'b0, x};
   endfunction

endpackage

// File: rtl/sym_fifo.sv
// Symbol FIFO: push lands one cycle later at the head; one pop per cycle.
// Backpressure: a push while full is dropped and counted unless a pop frees the slot in the same cycle.
module sym_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop_rdy,
   output logic [W-1:0] head_dat,
   output logic         head_vld,
   output logic [7:0]   overflow_count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [7:0]    ovf_q, ovf_d;
   logic          empty, full, pop, push_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop     = !empty && pop_rdy;
   assign push_ok = push_vld && (!full || pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      // When full, the write slot is the head being popped; readers see mem_q this cycle.
      if (push_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_dat;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      if (push_vld && !push_ok && (ovf_q != 8'hFF)) begin
         ovf_d = ovf_q + 8'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         mem_q    <= mem_d;
      end
   end

   assign head_dat       = mem_q[rd_ptr_q[AW-1:0]];
   assign head_vld       = !empty;
   assign overflow_count = ovf_q;

endmodule

// File: rtl/pwm_decode_sequencer.sv
// Gates decoder enable around each pulse burst and queues the settled symbol; sym_valid rises QUIET_LEN+DECODE_LAT+3 cycles after the last loud sample.
// Backpressure: sym_ready pops the FIFO head; symbols arriving at a full FIFO are dropped and counted.
module pwm_decode_sequencer
   import pwm_seq_pkg::*;
#(
   parameter int QUIET_LEN  = 16,
   parameter int MAX_LEN    = 1024,
   parameter int DECODE_LAT = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic signed [SAMPLE_W-1:0] ref_in,
   input  logic signed [SAMPLE_W-1:0] data_in,
   input  logic signed [SYM_W-1:0]    decoded_symbol,
   output logic                       enable_counter,
   output logic signed [SYM_W-1:0]    sym_out,
   output logic                       sym_valid,
   input  logic                       sym_ready,
   output logic                       busy,
   output logic                       timeout_pulse,
   output logic [7:0]                 overflow_count
);

   localparam logic [7:0]  QUIET_L = 8'(QUIET_LEN);
   localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
   localparam logic [3:0]  LAT_L   = 4'(DECODE_LAT);

   seq_state_t    state_q, state_d;
   logic          above_q, above_d;
   logic [15:0]   len_q, len_d;
   logic [7:0]    quiet_q, quiet_d;
   logic [3:0]    lat_q, lat_d;
   logic          push;
   logic          timeout;
   logic [SYM_W-1:0] head_dat;

   always_comb begin
      above_d = mag17(data_in) > clamp_ref(ref_in);
      state_d = state_q;
      len_d   = '0;
      quiet_d = '0;
      lat_d   = '0;
      push    = 1'b0;
      timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = ARMED;
         end
         ARMED: begin
            if (!start)       state_d = IDLE;
            else if (above_q) state_d = ACTIVE;
         end
         ACTIVE: begin
            len_d   = len_q + 16'd1;
            quiet_d = above_q ? 8'd0 : quiet_q + 8'd1;
            // End of burst takes priority over the length limit.
            if (quiet_d == QUIET_L) begin
               state_d = (DECODE_LAT == 0) ? EMIT : SETTLE;
            end else if (len_d == MAX_L) begin
               state_d = ARMED;
               timeout = 1'b1;
            end
         end
         SETTLE: begin
            lat_d = lat_q + 4'd1;
            if (lat_d == LAT_L) state_d = EMIT;
         end
         EMIT: begin
            push    = 1'b1;
            state_d = start ? ARMED : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         above_q <= 1'b0;
         len_q   <= '0;
         quiet_q <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         above_q <= above_d;
         len_q   <= len_d;
         quiet_q <= quiet_d;
         lat_q   <= lat_d;
      end
   end

   // Decoded straight from the state flop so reset drops it without waiting for a clock.
   assign enable_counter = (state_q == ACTIVE);
   assign busy           = (state_q != IDLE);
   assign timeout_pulse  = timeout;

   sym_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (SYM_W)
   ) u_fifo (
      .clock          (clock),
      .reset          (reset),
      .push_vld       (push),
      .push_dat       (decoded_symbol),
      .pop_rdy        (sym_ready),
      .head_dat       (head_dat),
      .head_vld       (sym_valid),
      .overflow_count (overflow_count)
   );

   assign sym_out = head_dat;

endmodule

// File: tb/tb_pwm_decode_sequencer.sv
// Directed bench for pwm_decode_sequencer: detection table plus hand-built burst, timeout,
// overflow, full-FIFO push/pop, reset and start-control sequences.
module tb_pwm_decode_sequencer;
   import pwm_seq_pkg::*;

   localparam int Q = 16;
   localparam int D = 2;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic signed [15:0] ref_in = '0;
   logic signed [15:0] data_in = '0;
   logic signed [7:0]  decoded_symbol = '0;
   logic               enable_counter;
   logic signed [7:0]  sym_out;
   logic               sym_valid;
   logic               sym_ready = 1'b0;
   logic               busy;
   logic               timeout_pulse;
   logic [7:0]         overflow_count;

   int n_chk  = 0;
   int n_fail = 0;

   pwm_decode_sequencer #(
      .QUIET_LEN  (Q),
      .MAX_LEN    (64),
      .DECODE_LAT (D),
      .FIFO_DEPTH (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .ref_in         (ref_in),
      .data_in        (data_in),
      .decoded_symbol (decoded_symbol),
      .enable_counter (enable_counter),
      .sym_out        (sym_out),
      .sym_valid      (sym_valid),
      .sym_ready      (sym_ready),
      .busy           (busy),
      .timeout_pulse  (timeout_pulse),
      .overflow_count (overflow_count)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic signed [15:0] ref_v;
      logic signed [15:0] data_v;
      logic signed [7:0]  sym;
      logic               det;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One loud sample then silence long enough for the symbol to be emitted.
   task automatic do_burst(input logic signed [7:0] sym);
      decoded_symbol = sym;
      data_in = 16'sd300;
      step();
      data_in = '0;
      repeat (Q + D + 6) step();
   endtask

   function automatic logic signed [15:0] nom_sample(input int n);
      int t;
      if (n < 28)       t = (n % 13) - 6;
      else if (n == 28) t = -237;
      else if (n == 29) t = 285;
      else if (n < 70)  t = (n % 21) - 10;
      else              t = 0;
      return 16'(t);
   endfunction

   initial begin
      int en_cycles, en_rises, first_valid, tcount;
      logic prev_en;
      logic signed [7:0] first_sym;

      tbl[0] = '{16'sd95,    -16'sd237,  8'sd11,  1'b1};
      tbl[1] = '{16'sd95,    16'sd285,   8'sd12,  1'b1};
      tbl[2] = '{16'sd95,    16'sd95,    8'sd13,  1'b0};
      tbl[3] = '{16'sd95,    -16'sd95,   8'sd14,  1'b0};
      tbl[4] = '{16'sd95,    16'sd96,    8'sd15,  1'b1};
      tbl[5] = '{16'sd32767, 16'sh8000,  -8'sd3,  1'b1};
      tbl[6] = '{16'sd32767, 16'sd32767, 8'sd0,   1'b0};
      tbl[7] = '{-16'sd5,    16'sd1,     8'sd21,  1'b1};
      tbl[8] = '{-16'sd5,    16'sd0,     8'sd22,  1'b0};
      tbl[9] = '{16'sd0,     -16'sd1,    8'sh80,  1'b1};

      // Reset state
      #2 reset = 1'b1;
      #2;
      chk("rst_enable", enable_counter, 0);
      chk("rst_sym_valid", sym_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_pulse, 0);
      chk("rst_overflow", overflow_count, 0);
      chk("rst_sym_out", sym_out, 0);
      @(negedge clock);
      reset = 1'b0;
      step();
      step();
      chk("idle_without_start", busy, 0);
      start = 1'b1;
      step();
      chk("armed_busy", busy, 1);
      sym_ready = 1'b1;

      // Detection table: the trigger shows on enable_counter two cycles after the sample.
      for (int i = 0; i < 10; i++) begin
         ref_in = tbl[i].ref_v;
         decoded_symbol = tbl[i].sym;
         data_in = tbl[i].data_v;
         step();
         data_in = '0;
         step();
         chk($sformatf("tbl%0d_enable", i), enable_counter, tbl[i].det);
         if (tbl[i].det) begin
            repeat (Q + D) step();
            chk($sformatf("tbl%0d_valid_early", i), sym_valid, 0);
            step();
            chk($sformatf("tbl%0d_valid", i), sym_valid, 1);
            chk($sformatf("tbl%0d_sym", i), sym_out, tbl[i].sym);
            repeat (3) step();
         end else begin
            repeat (4) step();
            chk($sformatf("tbl%0d_still_armed", i), dut.state_q, ARMED);
         end
      end

      // Nominal burst: loud samples at n=28,29; enable cycles 30..46; sym_valid at cycle 50.
      ref_in = 16'sd95;
      decoded_symbol = 8'sd11;
      en_cycles = 0;
      en_rises = 0;
      first_valid = -1;
      first_sym = '0;
      prev_en = 1'b0;
      for (int n = 0; n < 80; n++) begin
         data_in = nom_sample(n);
         step();
         if (enable_counter && !prev_en) en_rises++;
         if (enable_counter) en_cycles++;
         prev_en = enable_counter;
         if (sym_valid && first_valid < 0) begin
            first_valid = n + 1;
            first_sym = sym_out;
         end
      end
      chk("nom_enable_windows", en_rises, 1);
      chk("nom_enable_cycles", en_cycles, Q + 1);
      chk("nom_valid_cycle", first_valid, 29 + Q + D + 3);
      chk("nom_sym", first_sym, 11);
      chk("nom_overflow", overflow_count, 0);

      // Timeout: ACTIVE cycle k is observed after edge k+1.
      tcount = 0;
      data_in = 16'sd200;
      for (int k = 1; k <= 66; k++) begin
         step();
         if (timeout_pulse) tcount++;
         if (k == 64) chk("to_not_yet", timeout_pulse, 0);
         if (k == 65) begin
            chk("to_pulse", timeout_pulse, 1);
            chk("to_enable_at_pulse", enable_counter, 1);
         end
         if (k == 66) begin
            chk("to_enable_after", enable_counter, 0);
            chk("to_state_armed", dut.state_q, ARMED);
         end
      end
      chk("to_pulse_count", tcount, 1);
      chk("to_no_push", sym_valid, 0);
      data_in = '0;
      repeat (30) step();
      chk("to_drained", sym_valid, 0);

      // Overflow: six bursts into a four-entry FIFO.
      sym_ready = 1'b0;
      for (int k = 0; k < 6; k++) do_burst(8'(40 + k));
      chk("ovf_valid", sym_valid, 1);
      chk("ovf_count", overflow_count, 2);
      sym_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovf_pop%0d_valid", k), sym_valid, 1);
         chk($sformatf("ovf_pop%0d_sym", k), sym_out, 40 + k);
         step();
      end
      chk("ovf_empty", sym_valid, 0);

      // Full FIFO with a pop on the EMIT cycle: push accepted, no drop.
      sym_ready = 1'b0;
      for (int k = 0; k < 4; k++) do_burst(8'(70 + k));
      chk("pp_full_count", overflow_count, 2);
      decoded_symbol = 8'sd74;
      data_in = 16'sd300;
      step();
      data_in = '0;
      repeat (19) step();
      chk("pp_state_emit", dut.state_q, EMIT);
      sym_ready = 1'b1;
      step();
      sym_ready = 1'b0;
      chk("pp_overflow_same", overflow_count, 2);
      chk("pp_head", sym_out, 71);
      repeat (3) step();
      sym_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("pp_pop%0d_sym", k), sym_out, 71 + k);
         step();
      end
      chk("pp_empty", sym_valid, 0);

      // Reset during ACTIVE with a symbol held in the FIFO.
      sym_ready = 1'b0;
      do_burst(8'sd80);
      chk("rb_held", sym_valid, 1);
      decoded_symbol = 8'sd81;
      data_in = 16'sd300;
      step();
      data_in = '0;
      step();
      chk("rb_active", enable_counter, 1);
      #2 reset = 1'b1;
      #1;
      chk("rb_enable_async", enable_counter, 0);
      chk("rb_busy", busy, 0);
      chk("rb_fifo_empty", sym_valid, 0);
      chk("rb_overflow", overflow_count, 0);
      chk("rb_sym_out", sym_out, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (Q + D + 6) step();
      chk("rb_no_push", sym_valid, 0);
      chk("rb_rearmed", dut.state_q, ARMED);

      // start dropped during SETTLE: symbol still pushed, then IDLE.
      decoded_symbol = 8'sd33;
      data_in = 16'sd300;
      step();
      data_in = '0;
      repeat (17) step();
      chk("sc_state_settle", dut.state_q, SETTLE);
      start = 1'b0;
      repeat (3) step();
      chk("sc_valid", sym_valid, 1);
      chk("sc_sym", sym_out, 33);
      chk("sc_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_decode_sequencer.md
# pwm_decode_sequencer

Sequencing controller for the PWM symbol decoder (`decoder_top`). It watches the raw sample stream against the reference threshold and gates the decoder's `enable_counter` around each pulse burst. After the decoder output settles, it captures `decoded_symbol` into a small output FIFO behind a valid/ready handshake. It sits between the radio sample path and the downstream symbol consumer, and flags over-long bursts and FIFO overflow.

## Interface
Parameters:
- `QUIET_LEN`, 16: consecutive below-threshold samples that end a burst (range 1..255).
- `MAX_LEN`, 1024: maximum burst length in cycles before timeout (range 2..65535).
- `DECODE_LAT`, 2: cycles from `enable_counter` deassertion to a valid `decoded_symbol` (range 0..15).
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).

Ports:
- `clock`, in, 1: single clock for all logic.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `start`, in, 1: level; high arms the sequencer.
- `ref_in`, in, 16 signed: detection threshold, sampled every cycle; negative values are treated as 0.
- `data_in`, in, 16 signed: raw sample, one per cycle.
- `decoded_symbol`, in, 8 signed: from `decoder_top`.
- `enable_counter`, out, 1: to `decoder_top`.
- `sym_out`, out, 8 signed: FIFO head.
- `sym_valid`, out, 1: FIFO not empty.
- `sym_ready`, in, 1: consumer accepts the head this cycle.
- `busy`, out, 1: state is not IDLE.
- `timeout_pulse`, out, 1: one-cycle pulse when a burst is aborted.
- `overflow_count`, out, 8: symbols dropped because the FIFO was full; saturates at 255.

## Operation
- **Detection:** `above_q <= |data_in| > max(ref_in, 0)`, registered.
  - Use 17-bit magnitude so that -32768 yields 32768 with no wrap.
  - Equality counts as below.
- **States:**
  - IDLE → ARMED when `start`=1.
  - ARMED → ACTIVE when `above_q`=1.
    - `len_cnt` is cleared on entry to ACTIVE.
    - `quiet_cnt` is cleared on entry to ACTIVE.
  - ACTIVE: `enable_counter`=1.
    - `len_cnt` increments every cycle.
    - `quiet_cnt` increments while `above_q`=0 and clears while `above_q`=1.
    - When `quiet_cnt`==`QUIET_LEN`: go to SETTLE.
    - Otherwise, when `len_cnt`==`MAX_LEN`: go to ARMED, assert `timeout_pulse`, push nothing.
    - If both conditions hold in the same cycle, SETTLE wins.
  - SETTLE: `enable_counter`=0; wait `DECODE_LAT` cycles via `lat_cnt`, then go to EMIT.
  - EMIT: push `decoded_symbol` for one cycle, then go to ARMED if `start`=1, else IDLE.
  - ARMED → IDLE when `start`=0.
  - Deasserting `start` in ACTIVE or SETTLE does not abort; the current symbol completes.
- **FIFO:**
  - Pop when `sym_valid`&&`sym_ready`.
  - A push while full with no pop: the symbol is dropped and `overflow_count` increments, saturating.
  - A push while full with a pop in the same cycle: the push is accepted.
  - A pop while empty is ignored.
- **Reset values:**
  - Outputs `enable_counter`, `sym_valid`, `busy`, `timeout_pulse` are 0; `overflow_count`=0; `sym_out`=0.
  - Internal: state is IDLE and the FIFO is empty.
- **Reset mid-burst:** `enable_counter` drops immediately and asynchronously; no symbol is pushed.

## Timing
- `above_q` lags `data_in` by 1 cycle.
- `enable_counter` rises 1 cycle after the first `above_q`=1 seen in ARMED, i.e. 2 cycles after the triggering sample.
- The ACTIVE → SETTLE transition happens on the cycle where `quiet_cnt` reaches `QUIET_LEN`.
- EMIT follows `DECODE_LAT` cycles later.
- `sym_valid` rises the cycle after EMIT.
- End-to-end latency from the last above-threshold sample to `sym_valid`: `QUIET_LEN`+`DECODE_LAT`+3 cycles.
- `sym_out` is stable while `sym_valid`=1 and no pop occurs.
- FIFO throughput: one pop per cycle.

## Structure
- Package `pwm_seq_pkg` holds:
  - the state enum (IDLE, ARMED, ACTIVE, SETTLE, EMIT);
  - `SAMPLE_W`=16 and `SYM_W`=8;
  - the 17-bit magnitude function.
- Sub-module `sym_fifo`: synchronous FIFO with the full/empty/overflow semantics above.
- The FSM and counters live in the top module.

## Test plan
1. **Nominal burst:** `ref_in`=95, 28 samples of |x|≤6, then a 2-cycle excursion peaking at -237 and +285, then 40 samples of |x|≤10; stub `decoded_symbol`=11.
   - Exactly one `enable_counter` window.
   - `sym_out`=11 with `sym_valid` at the computed latency.
   - `overflow_count`=0.
2. **Timeout:** `MAX_LEN`=64 with a constant sample of 200.
   - `timeout_pulse` fires once at cycle 64 of ACTIVE.
   - No push occurs.
   - State returns to ARMED.
3. **Overflow:** `sym_ready`=0, then 6 bursts with `FIFO_DEPTH`=4.
   - 4 symbols are held and `overflow_count`=2.
   - Then `sym_ready`=1: 4 pops occur in order.
4. **Simultaneous push/pop while full:** EMIT coincides with `sym_ready`=1 on a full FIFO.
   - The push is accepted and `overflow_count` is unchanged.
5. **Edge cases:**
   - `data_in`=-32768 with `ref_in`=32767 is detected as above.
   - `ref_in`=-5 behaves as a threshold of 0.
6. **Reset and start control:**
   - `reset` pulse during ACTIVE: `enable_counter`=0 immediately, state IDLE, FIFO empty.
   - `start`=0 during SETTLE: the symbol is still pushed, then the state is IDLE.
